// File: rtl/spi_pkg.sv
// spi_pkg
// Shared constants for the SPI bus arbiter slice.
//   - FSM state codes (IDLE, SETUP, GRANT, GAP) as 2-bit constants
//   - owner codes (NONE = 0, SDC = 1, LCD = 2)
//   - default settle/gap lengths and default SPI_clk divider selects
//   - cnt_width(): width of the shared settle/gap down-counter
package spi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_SDC  = 2'd1;
  localparam logic [1:0] OWN_LCD  = 2'd2;

  localparam int DEF_SETTLE     = 4;
  localparam int DEF_GAP_CYCLES = 8;

  localparam logic [1:0] DEF_CLK_SEL_SDC = 2'd2;
  localparam logic [1:0] DEF_CLK_SEL_LCD = 2'd1;

  // Counter must hold max(a,b); never narrower than one bit so that
  // SETTLE = GAP_CYCLES = 0 still elaborates.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if
// Bundles the requester handshakes, the engine-side SPI signals and the
// pad-side SPI signals of the arbiter.
//   master : arbiter view (engine/requester signals in, grants and pads out)
//   slave  : engine/pad view (drives requests and engine pins, sees grants)
interface spi_bus_arbiter_if;

  logic       i_req_sdc;
  logic       i_sdc_mosi;
  logic       i_sdc_cs;
  logic       o_gnt_sdc;
  logic       i_req_lcd;
  logic       i_lcd_mosi;
  logic       i_lcd_dc;
  logic       i_lcd_cs;
  logic       o_gnt_lcd;
  logic       o_mosi;
  logic       o_dc;
  logic       o_cs_sdc;
  logic       o_cs_lcd;
  logic [1:0] o_clk_sel;
  logic [1:0] o_owner;
  logic       o_busy;

  modport master (
    input  i_req_sdc, i_sdc_mosi, i_sdc_cs,
    input  i_req_lcd, i_lcd_mosi, i_lcd_dc, i_lcd_cs,
    output o_gnt_sdc, o_gnt_lcd,
    output o_mosi, o_dc, o_cs_sdc, o_cs_lcd,
    output o_clk_sel, o_owner, o_busy
  );

  modport slave (
    output i_req_sdc, i_sdc_mosi, i_sdc_cs,
    output i_req_lcd, i_lcd_mosi, i_lcd_dc, i_lcd_cs,
    input  o_gnt_sdc, o_gnt_lcd,
    input  o_mosi, o_dc, o_cs_sdc, o_cs_lcd,
    input  o_clk_sel, o_owner, o_busy
  );

endinterface

// File: rtl/spi_arb_timer.sv
// spi_arb_timer
// Loadable down-counter shared by the SETUP (clock settle) and GAP phases.
//   i_clk       : system clock
//   w_rst       : async active-high reset (count -> 0)
//   load_i      : load load_val_i (has priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one, saturating at zero
//   done_o      : current count <= 1, i.e. the phase ends on this edge
module spi_arb_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         w_rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A loaded value of N ends the phase on the Nth edge; 0 and 1 both end it
  // on the first edge.
  assign done_o = (cnt_q <= ONE);

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
// Shares one SPI bus between the SD-card and LCD engines with a req/gnt
// handshake: programs the divider select for the winner, waits SETTLE
// cycles, grants, then holds the bus idle for GAP_CYCLES after release.
//   i_clk : system clock
//   w_rst : async active-high reset
//   bus   : spi_bus_arbiter_if.master (requests, engine pins, grants, pads,
//           o_clk_sel, o_owner, o_busy)
module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int         SETTLE      = DEF_SETTLE,
  parameter int         GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter logic [1:0] CLK_SEL_SDC = DEF_CLK_SEL_SDC,
  parameter logic [1:0] CLK_SEL_LCD = DEF_CLK_SEL_LCD
) (
  input  logic               i_clk,
  input  logic               w_rst,
  spi_bus_arbiter_if.master  bus
);

  localparam int CW = cnt_width(SETTLE, GAP_CYCLES);

  logic [1:0] state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [1:0] clk_sel_q, clk_sel_d;
  logic       gnt_sdc_q, gnt_sdc_d;
  logic       gnt_lcd_q, gnt_lcd_d;

  logic [1:0]    pick;
  logic          owner_req;
  logic          tmr_load, tmr_dec, tmr_done;
  logic [CW-1:0] tmr_val;

  spi_arb_timer #(.W(CW)) u_timer (
    .i_clk      (i_clk),
    .w_rst      (w_rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .done_o     (tmr_done)
  );

  // Round robin on a tie: whoever did not hold the bus last wins.
  always_comb begin
    pick = OWN_NONE;
    if (bus.i_req_sdc && bus.i_req_lcd)
      pick = (last_q == OWN_SDC) ? OWN_LCD : OWN_SDC;
    else if (bus.i_req_sdc)
      pick = OWN_SDC;
    else if (bus.i_req_lcd)
      pick = OWN_LCD;
  end

  always_comb begin
    owner_req = 1'b0;
    if (owner_q == OWN_SDC)      owner_req = bus.i_req_sdc;
    else if (owner_q == OWN_LCD) owner_req = bus.i_req_lcd;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    clk_sel_d = clk_sel_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    tmr_val   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick != OWN_NONE) begin
          state_d   = ST_SETUP;
          owner_d   = pick;
          clk_sel_d = (pick == OWN_SDC) ? CLK_SEL_SDC : CLK_SEL_LCD;
          tmr_load  = 1'b1;
          tmr_val   = CW'(SETTLE);
        end
      end
      ST_SETUP: begin
        // The bus never toggled, so an abort returns straight to IDLE
        // without a gap and without touching last_owner.
        if (!owner_req) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
        end else if (tmr_done) begin
          state_d = ST_GRANT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          state_d  = ST_GAP;
          last_d   = owner_q;
          owner_d  = OWN_NONE;
          tmr_load = 1'b1;
          tmr_val  = CW'(GAP_CYCLES);
        end
      end
      ST_GAP: begin
        if (tmr_done) state_d = ST_IDLE;
        else          tmr_dec = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt_sdc_d = (state_d == ST_GRANT) && (owner_d == OWN_SDC);
  assign gnt_lcd_d = (state_d == ST_GRANT) && (owner_d == OWN_LCD);

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      last_q    <= OWN_LCD;
      clk_sel_q <= CLK_SEL_SDC;
      gnt_sdc_q <= 1'b0;
      gnt_lcd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      clk_sel_q <= clk_sel_d;
      gnt_sdc_q <= gnt_sdc_d;
      gnt_lcd_q <= gnt_lcd_d;
    end
  end

  // Pads follow the owner combinationally so engine-to-pad latency is zero;
  // outside GRANT both grants are low and the bus sits at its idle levels.
  assign bus.o_gnt_sdc = gnt_sdc_q;
  assign bus.o_gnt_lcd = gnt_lcd_q;
  assign bus.o_mosi    = gnt_sdc_q ? bus.i_sdc_mosi :
                         gnt_lcd_q ? bus.i_lcd_mosi : 1'b1;
  assign bus.o_dc      = gnt_lcd_q & bus.i_lcd_dc;
  assign bus.o_cs_sdc  = gnt_sdc_q ? bus.i_sdc_cs : 1'b1;
  assign bus.o_cs_lcd  = gnt_lcd_q ? bus.i_lcd_cs : 1'b1;
  assign bus.o_clk_sel = clk_sel_q;
  assign bus.o_owner   = owner_q;
  assign bus.o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter
// Self-checking bench for spi_bus_arbiter. Expected grants (owner and edge
// number) are queued when requests are driven and compared when a grant
// appears; each scenario task also checks pad levels inline.
module tb_spi_bus_arbiter;
  import spi_pkg::*;

  localparam int SETTLE = 4;
  localparam int GAP    = 8;

  // {mosi, dc, cs_sdc, cs_lcd, gnt_sdc, gnt_lcd, clk_sel, owner, busy}
  localparam logic [10:0] IDLE_VEC = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                      2'd2, 2'd0, 1'b0};

  logic i_clk = 1'b0;
  logic w_rst = 1'b1;

  spi_bus_arbiter_if bus();

  spi_bus_arbiter #(
    .SETTLE      (SETTLE),
    .GAP_CYCLES  (GAP),
    .CLK_SEL_SDC (2'd2),
    .CLK_SEL_LCD (2'd1)
  ) dut (
    .i_clk (i_clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] owner;
    int         cyc;
  } exp_t;
  exp_t sbq[$];

  logic [1:0] tbLast;

  // The two grants must never be high together.
  always @(negedge i_clk) begin
    if (!w_rst) begin
      checks++;
      if (bus.o_gnt_sdc && bus.o_gnt_lcd) begin
        errors++;
        $display("[TB] FAIL gnt_overlap at cycle %0d: both grants high, required at most one", cyc);
      end
    end
  end

  function automatic logic [10:0] obs();
    return {bus.o_mosi, bus.o_dc, bus.o_cs_sdc, bus.o_cs_lcd, bus.o_gnt_sdc,
            bus.o_gnt_lcd, bus.o_clk_sel, bus.o_owner, bus.o_busy};
  endfunction

  task automatic push_exp(input logic [1:0] owner, input int at);
    exp_t e;
    e.owner = owner;
    e.cyc   = at;
    sbq.push_back(e);
  endtask

  task automatic wait_gnt(output int at, output logic [1:0] who);
    bit found;
    found = 0;
    at    = -1;
    who   = OWN_NONE;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge i_clk);
      if (bus.o_gnt_sdc || bus.o_gnt_lcd) begin
        found = 1;
        at    = cyc;
        who   = bus.o_gnt_sdc ? OWN_SDC : OWN_LCD;
      end
    end
  endtask

  task automatic wait_idle(output int at);
    bit found;
    found = 0;
    at    = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge i_clk);
      if (!bus.o_busy) begin
        found = 1;
        at    = cyc;
      end
    end
  endtask

  task automatic idle_engines();
    bus.i_sdc_mosi = 1'b0;
    bus.i_sdc_cs   = 1'b1;
    bus.i_lcd_mosi = 1'b0;
    bus.i_lcd_dc   = 1'b0;
    bus.i_lcd_cs   = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (obs() !== IDLE_VEC) begin
      errors++;
      $display("[TB] FAIL reset_in: got %b required %b", obs(), IDLE_VEC);
    end
    @(negedge i_clk);
    w_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++;
    if (obs() !== IDLE_VEC) begin
      errors++;
      $display("[TB] FAIL reset_after: got %b required %b", obs(), IDLE_VEC);
    end
  endtask

  task automatic test_tie_after_reset();
    int c, m, at;
    logic [1:0] who;
    exp_t e;
    c = cyc;
    bus.i_req_sdc = 1'b1;
    bus.i_req_lcd = 1'b1;
    push_exp(OWN_SDC, c + 1 + SETTLE);
    wait_gnt(at, who);
    e = sbq.pop_front();
    checks++;
    if (who !== e.owner || at !== e.cyc) begin
      errors++;
      $display("[TB] FAIL tie_first: got owner %0d at %0d required owner %0d at %0d", who, at, e.owner, e.cyc);
    end
    bus.i_sdc_cs = 1'b0; bus.i_lcd_cs = 1'b0;
    bus.i_sdc_mosi = 1'b0; bus.i_lcd_mosi = 1'b1; bus.i_lcd_dc = 1'b1;
    #1;
    checks++;
    if ({bus.o_mosi, bus.o_dc, bus.o_cs_sdc, bus.o_cs_lcd} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL tie_sd_bus: got %b required 0001", {bus.o_mosi, bus.o_dc, bus.o_cs_sdc, bus.o_cs_lcd});
    end
    @(negedge i_clk);
    c = cyc;
    bus.i_req_sdc = 1'b0;
    m = c + 1;
    push_exp(OWN_LCD, m + GAP + 1 + SETTLE);
    for (int i = 0; i <= GAP; i++) begin
      @(negedge i_clk);
      checks++;
      if ({bus.o_cs_sdc, bus.o_cs_lcd, bus.o_gnt_sdc, bus.o_gnt_lcd, bus.o_mosi} !== 5'b11001) begin
        errors++;
        $display("[TB] FAIL gap_idle at cycle %0d: got %b required 11001", cyc,
                 {bus.o_cs_sdc, bus.o_cs_lcd, bus.o_gnt_sdc, bus.o_gnt_lcd, bus.o_mosi});
      end
    end
    @(negedge i_clk);
    checks++;
    if ({bus.o_clk_sel, bus.o_owner, bus.o_busy} !== {2'd1, OWN_LCD, 1'b1}) begin
      errors++;
      $display("[TB] FAIL lcd_setup at cycle %0d: got %b required %b", cyc,
               {bus.o_clk_sel, bus.o_owner, bus.o_busy}, {2'd1, OWN_LCD, 1'b1});
    end
    wait_gnt(at, who);
    e = sbq.pop_front();
    checks++;
    if (who !== e.owner || at !== e.cyc) begin
      errors++;
      $display("[TB] FAIL tie_second: got owner %0d at %0d required owner %0d at %0d", who, at, e.owner, e.cyc);
    end
    for (int i = 0; i < 2; i++) begin
      bus.i_lcd_dc   = i[0];
      bus.i_lcd_mosi = ~i[0];
      #1;
      checks++;
      if ({bus.o_dc, bus.o_mosi, bus.o_cs_lcd, bus.o_cs_sdc} !== {i[0], ~i[0], 1'b0, 1'b1}) begin
        errors++;
        $display("[TB] FAIL lcd_bus step %0d: got %b required %b", i,
                 {bus.o_dc, bus.o_mosi, bus.o_cs_lcd, bus.o_cs_sdc}, {i[0], ~i[0], 1'b0, 1'b1});
      end
    end
    @(negedge i_clk);
    bus.i_req_lcd = 1'b0;
    tbLast = OWN_LCD;
    idle_engines();
    wait_idle(at);
  endtask

  task automatic test_round_robin();
    int c, at;
    logic [1:0] who, want;
    exp_t e;
    for (int r = 0; r < 2; r++) begin
      want = (tbLast == OWN_SDC) ? OWN_LCD : OWN_SDC;
      @(negedge i_clk);
      c = cyc;
      bus.i_req_sdc = 1'b1;
      bus.i_req_lcd = 1'b1;
      push_exp(want, c + 1 + SETTLE);
      wait_gnt(at, who);
      e = sbq.pop_front();
      checks++;
      if (who !== e.owner || at !== e.cyc || bus.o_clk_sel !== ((want == OWN_SDC) ? 2'd2 : 2'd1)) begin
        errors++;
        $display("[TB] FAIL rr_round %0d: got owner %0d at %0d sel %0d required owner %0d at %0d",
                 r, who, at, bus.o_clk_sel, e.owner, e.cyc);
      end
      @(negedge i_clk);
      c = cyc;
      bus.i_req_sdc = 1'b0;
      bus.i_req_lcd = 1'b0;
      tbLast = want;
      wait_idle(at);
      checks++;
      if (at !== c + 1 + GAP) begin
        errors++;
        $display("[TB] FAIL rr_idle %0d: got cycle %0d required %0d", r, at, c + 1 + GAP);
      end
    end
  endtask

  task automatic test_sd_alone();
    int c, at;
    logic [1:0] who;
    exp_t e;
    @(negedge i_clk);
    c = cyc;
    bus.i_req_sdc = 1'b1;
    push_exp(OWN_SDC, c + 1 + SETTLE);
    @(negedge i_clk);
    checks++;
    if ({bus.o_clk_sel, bus.o_owner, bus.o_busy, bus.o_gnt_sdc} !== {2'd2, OWN_SDC, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL sd_setup: got %b required %b",
               {bus.o_clk_sel, bus.o_owner, bus.o_busy, bus.o_gnt_sdc}, {2'd2, OWN_SDC, 1'b1, 1'b0});
    end
    wait_gnt(at, who);
    e = sbq.pop_front();
    checks++;
    if (who !== e.owner || at !== e.cyc) begin
      errors++;
      $display("[TB] FAIL sd_grant: got owner %0d at %0d required owner %0d at %0d", who, at, e.owner, e.cyc);
    end
    bus.i_sdc_cs = 1'b0;
    bus.i_lcd_cs = 1'b0;
    bus.i_lcd_dc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_sdc_mosi = i[0];
      bus.i_lcd_mosi = ~i[0];
      #1;
      checks++;
      if ({bus.o_mosi, bus.o_cs_sdc, bus.o_cs_lcd, bus.o_dc} !== {i[0], 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL sd_bus step %0d: got %b required %b", i,
                 {bus.o_mosi, bus.o_cs_sdc, bus.o_cs_lcd, bus.o_dc}, {i[0], 1'b0, 1'b1, 1'b0});
      end
    end
    @(negedge i_clk);
    bus.i_req_sdc = 1'b0;
    tbLast = OWN_SDC;
    @(negedge i_clk);
    checks++;
    if ({bus.o_gnt_sdc, bus.o_cs_sdc, bus.o_mosi, bus.o_busy} !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL sd_release: got %b required 0111", {bus.o_gnt_sdc, bus.o_cs_sdc, bus.o_mosi, bus.o_busy});
    end
    idle_engines();
    wait_idle(at);
  endtask

  task automatic test_abort();
    int c, at;
    bit seen;
    logic [1:0] who;
    exp_t e;
    @(negedge i_clk);
    bus.i_req_lcd = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    bus.i_req_lcd = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({bus.o_busy, bus.o_owner, bus.o_clk_sel} !== {1'b0, OWN_NONE, 2'd1}) begin
      errors++;
      $display("[TB] FAIL abort_idle: got %b required %b",
               {bus.o_busy, bus.o_owner, bus.o_clk_sel}, {1'b0, OWN_NONE, 2'd1});
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (bus.o_gnt_lcd || bus.o_busy) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got activity %0d required 0", seen);
    end
    c = cyc;
    bus.i_req_sdc = 1'b1;
    bus.i_req_lcd = 1'b1;
    push_exp((tbLast == OWN_SDC) ? OWN_LCD : OWN_SDC, c + 1 + SETTLE);
    wait_gnt(at, who);
    e = sbq.pop_front();
    checks++;
    if (who !== e.owner || at !== e.cyc) begin
      errors++;
      $display("[TB] FAIL abort_last: got owner %0d at %0d required owner %0d at %0d", who, at, e.owner, e.cyc);
    end
    @(negedge i_clk);
    bus.i_req_sdc = 1'b0;
    bus.i_req_lcd = 1'b0;
    tbLast = e.owner;
    wait_idle(at);
  endtask

  task automatic test_back_to_back();
    int c, at;
    bit bad;
    logic [1:0] who;
    exp_t e;
    @(negedge i_clk);
    c = cyc;
    bus.i_req_sdc = 1'b1;
    push_exp(OWN_SDC, c + 1 + SETTLE);
    wait_gnt(at, who);
    e = sbq.pop_front();
    checks++;
    if (who !== e.owner || at !== e.cyc) begin
      errors++;
      $display("[TB] FAIL b2b_sd: got owner %0d at %0d required owner %0d at %0d", who, at, e.owner, e.cyc);
    end
    bus.i_req_lcd = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (bus.o_gnt_lcd || !bus.o_gnt_sdc) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got preempt %0d required 0", bad);
    end
    c = cyc;
    bus.i_req_sdc = 1'b0;
    tbLast = OWN_SDC;
    push_exp(OWN_LCD, c + 1 + GAP + 1 + SETTLE);
    wait_gnt(at, who);
    e = sbq.pop_front();
    checks++;
    if (who !== e.owner || at !== e.cyc) begin
      errors++;
      $display("[TB] FAIL b2b_lcd: got owner %0d at %0d required owner %0d at %0d", who, at, e.owner, e.cyc);
    end
    @(negedge i_clk);
    bus.i_req_lcd = 1'b0;
    tbLast = OWN_LCD;
    wait_idle(at);
  endtask

  task automatic test_async_reset();
    int at;
    logic [1:0] who;
    exp_t e;
    @(negedge i_clk);
    bus.i_req_sdc = 1'b1;
    push_exp(OWN_SDC, cyc + 1 + SETTLE);
    wait_gnt(at, who);
    e = sbq.pop_front();
    bus.i_sdc_cs   = 1'b0;
    bus.i_sdc_mosi = 1'b0;
    bus.i_lcd_dc   = 1'b1;
    #1;
    checks++;
    if (who !== e.owner || {bus.o_mosi, bus.o_cs_sdc, bus.o_gnt_sdc} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL rst_pre: got owner %0d bus %b required owner %0d bus 001", who,
               {bus.o_mosi, bus.o_cs_sdc, bus.o_gnt_sdc}, e.owner);
    end
    #2;
    w_rst = 1'b1;
    #1;
    checks++;
    if (obs() !== IDLE_VEC) begin
      errors++;
      $display("[TB] FAIL rst_async: got %b required %b", obs(), IDLE_VEC);
    end
    @(negedge i_clk);
    bus.i_req_sdc = 1'b0;
    idle_engines();
    w_rst = 1'b0;
    tbLast = OWN_LCD;
    @(negedge i_clk);
  endtask

  initial begin
    bus.i_req_sdc = 1'b0;
    bus.i_req_lcd = 1'b0;
    idle_engines();
    tbLast = OWN_LCD;
    repeat (3) @(negedge i_clk);
    $display("[TB] start");
    test_reset();
    test_tie_after_reset();
    test_round_robin();
    test_sd_alone();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the single SPI bus (MOSI, SCLK divider select, DC, two chip selects) between the SD-card requester and the LCD requester. It replaces the fixed-order output muxing in the SPI top level with a req/gnt handshake. The block programs the SPI_clk divider select for the winning owner, waits for the clock to settle, grants the bus, and then enforces an idle gap with both CS high between owners. It sits between the SPI_*_sdc / SPI_* LCD engines and the pads.

## Interface
- SETTLE, 4: i_clk cycles spent in SETUP after the divider select changes, before grant.
- GAP_CYCLES, 8: i_clk cycles in GAP after release; all bus outputs are idle and both CS are high.
- CLK_SEL_SDC, 2: divider select driven while the SD card owns or is being set up.
- CLK_SEL_LCD, 1: divider select driven while the LCD owns or is being set up.

Reset and clock (already decided): reset w_rst, asynchronous, active-high; clock i_clk.

- i_clk  in  1  system clock (27 MHz)
- w_rst  in  1  async active-high reset
- i_req_sdc  in  1  SD requester holds high for the whole transaction
- i_sdc_mosi  in  1  SD engine MOSI
- i_sdc_cs  in  1  SD engine CS (active-low)
- o_gnt_sdc  out  1  SD owns bus
- i_req_lcd  in  1  LCD requester, level
- i_lcd_mosi  in  1  LCD engine MOSI
- i_lcd_dc  in  1  LCD engine DC
- i_lcd_cs  in  1  LCD engine CS (active-low)
- o_gnt_lcd  out  1  LCD owns bus
- o_mosi  out  1  bus MOSI
- o_dc  out  1  bus DC
- o_cs_sdc  out  1  SD card CS pad
- o_cs_lcd  out  1  LCD CS pad
- o_clk_sel  out  2  to SPI_clk i_state
- o_owner  out  2  0 none, 1 SDC, 2 LCD (valid in SETUP and GRANT)
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, SETUP, GRANT, GAP. Registers: state, owner, last_owner, counter.
- IDLE:
  - If no request is pending, stay.
  - If exactly one request is pending, owner = that requester.
  - If both are pending, owner = the requester that is not last_owner (round robin).
  - last_owner resets to LCD, so the SD card wins the first tie after reset.
  - On the transition, o_clk_sel is loaded with the owner's constant and the counter is loaded.
- SETUP:
  - Counts SETTLE cycles, then moves to GRANT.
  - If the owner's req drops during SETUP, go to IDLE on the next edge. No grant is issued and no gap is taken, because the bus never toggled.
- GRANT:
  - o_gnt_<owner> = 1.
  - The bus follows the owner: o_mosi = owner MOSI; o_cs_<owner> = owner CS.
  - The non-owner CS is forced to 1.
  - o_dc = i_lcd_dc when the owner is LCD, else 0.
  - A drop of the owner's req moves the state to GAP, and last_owner is set to owner.
  - Requests from the other side during GRANT are ignored until IDLE.
- GAP:
  - Bus outputs are idle.
  - Counts GAP_CYCLES, then goes to IDLE.
  - Requests raised during GAP stay pending and are arbitrated in IDLE.
- Idle bus values (IDLE, SETUP, GAP, reset): o_mosi = 1, o_dc = 0, o_cs_sdc = 1, o_cs_lcd = 1, both gnt = 0.
- o_clk_sel holds its last value in IDLE and GAP, so the divider never changes while a CS is low.
- Reset values:
  - state = IDLE, owner = none, last_owner = LCD, counter = 0.
  - o_clk_sel = CLK_SEL_SDC.
  - o_busy = 0, o_owner = 0, all bus outputs idle.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). In-flight engines are reset by the same w_rst.
- Counter is $clog2(max(SETTLE,GAP_CYCLES)+1) bits wide and does not wrap. SETTLE = 0 or GAP_CYCLES = 0 skips that state (next edge).

## Timing
- All state, gnt and o_clk_sel are registered. The bus muxing (mosi, dc, cs) is combinational from the registered owner/state plus engine inputs, so there is zero-cycle latency from engine to pad.
- Grant:
  - req sampled high at edge k: SETUP from k, o_clk_sel valid from k.
  - o_gnt rises after edge k+SETTLE.
- Release:
  - req sampled low at edge m: gnt falls and the bus goes idle after m.
  - IDLE from m+GAP_CYCLES.
  - The earliest next SETUP is at edge m+GAP_CYCLES+1.
- Minimum CS-high interval between owners = GAP_CYCLES+1+SETTLE i_clk cycles.
- Engines must not start until their gnt is seen high. The requester must hold req until its transaction's o_done.

## Structure
- Shared package spi_pkg:
  - state enum: IDLE, SETUP, GRANT, GAP.
  - owner codes: NONE = 0, SDC = 1, LCD = 2.
  - default divider selects CLK_SEL_SDC / CLK_SEL_LCD.
- One sub-module, spi_arb_timer: a loadable down-counter with a done flag, shared by SETUP and GAP.
- The FSM and muxing stay in spi_bus_arbiter.

## Test plan
- Reset: assert w_rst mid-GRANT (SD owner) -> o_mosi = 1, o_dc = 0, both CS = 1, gnt = 0, o_clk_sel = 2, o_busy = 0 without waiting for an edge.
- SD alone, SETTLE = 4: i_req_sdc sampled at edge 10 -> o_clk_sel = 2 after 10, o_gnt_sdc = 1 after 14. Then i_sdc_cs = 0 -> o_cs_sdc = 0, while i_lcd_cs = 0 -> o_cs_lcd stays 1, and o_mosi tracks i_sdc_mosi.
- Simultaneous requests after reset -> SD granted first. When SD releases at edge m with GAP_CYCLES = 8: both CS high through m+8, LCD SETUP at m+9 with o_clk_sel = 1, o_gnt_lcd at m+13, o_dc tracks i_lcd_dc.
- Round robin: LCD finishes, then both request in the same IDLE cycle -> SD wins. SD finishes, both request again -> LCD wins.
- Abort: i_req_lcd drops during SETUP (cycle 2 of 4) -> IDLE next edge, o_gnt_lcd never pulses, no GAP, last_owner unchanged.
- LCD requests during SD GRANT -> held pending. Granted only after SD release + GAP + 1 + SETTLE. No overlap of the two gnt signals at any cycle.
